wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 DATA_W, 32, data width of register-file write data.
REQ-002 REG_W, 5, register index width; 2**REG_W architectural registers.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 iAluVld  input  1  ALU result valid this cycle.
REQ-006 iAluDst  input  REG_W  ALU destination register.
REQ-007 iAluData  input  DATA_W  ALU result.
REQ-008 iLdIssue  input  1  load issued to memory this cycle.
REQ-009 iLdDst  input  REG_W  destination of issued load.
REQ-010 iLdRspVld  input  1  load data returning (in issue order).
REQ-011 iLdRspData  input  DATA_W  returned load data.
REQ-012 oRegWr  output  1  register-file write enable (registered).
REQ-013 oWrReg3  output  REG_W  register-file write index (registered).
REQ-014 oWrData  output  DATA_W  register-file write data (registered).
REQ-015 oAluStall  output  1  ALU FIFO full; upstream holds iAluVld low.
REQ-016 oLdStall  output  1  load tag queue full; no new iLdIssue.
REQ-017 oPend  output  2**REG_W  per-register load-pending scoreboard.
REQ-018 oErr  output  1  sticky protocol-error flag.
REQ-019 iFwdReg  input  REG_W  forwarding lookup index (WB_FWD_EN only).
REQ-020 oFwdHit / oFwdData  output  1 / DATA_W  forwarding result (WB_FWD_EN only).

Function
REQ-021 Single write port; load response has priority over ALU results every cycle.
REQ-022 ALU results enter 2-entry in-order FIFO; ALU result with iAluDst==0 is discarded, not enqueued.
REQ-023 Bypass: FIFO empty and iLdRspVld==0 in cycle N -> ALU write on oRegWr at cycle N+1 (one-cycle latency); else enqueued.
REQ-024 Each cycle without iLdRspVld, FIFO head (if any) drives oRegWr/oWrReg3/oWrData next cycle and is popped.
REQ-025 Simultaneous enqueue and pop on full FIFO permitted; oAluStall = (count==2) registered-state based.
REQ-026 iAluVld while FIFO full and no pop that cycle -> result dropped, oErr set.
REQ-027 Load tag queue: 2-entry in-order FIFO of iLdDst; push on iLdIssue, pop on iLdRspVld; oLdStall = (count==2).
REQ-028 iLdRspVld with empty tag queue -> ignored, oErr set; iLdIssue while full and no pop -> dropped, oErr set.
REQ-029 Load to dest 0: tag pushed/popped normally, oRegWr stays 0 for that response.
REQ-030 oPend[d] set at edge of iLdIssue (d!=0); cleared at edge loading oRegWr for that load; same-edge set and clear on same d -> set wins.
REQ-031 oPend[0] always 0; oRegWr never asserted with oWrReg3==0.
REQ-032 oRegWr deasserts the cycle after the last queued write; oWrReg3/oWrData hold last value when oRegWr==0.

Reset
REQ-033 resetn low: oRegWr=0, oWrReg3=0, oWrData=0, both FIFOs empty, oPend=0, oErr=0, oAluStall=0, oLdStall=0.
REQ-034 Reset asserted mid-operation discards all queued results and outstanding load tags; no write issued after release until new input.

Configuration
REQ-035 WB_FWD_EN defined: oFwdHit = oRegWr && oWrReg3==iFwdReg && iFwdReg!=0, oFwdData = oWrData (combinational), covering register-file one-cycle read latency.
REQ-036 WB_FWD_EN undefined: iFwdReg unused, oFwdHit=0, oFwdData=0.

Verification
REQ-037 Reset, then iAluVld dst=5 data=0x1234 in cycle 1 -> cycle 2 oRegWr=1, oWrReg3=5, oWrData=0x1234; cycle 3 oRegWr=0.
REQ-038 iLdIssue dst=7 cycle 1; cycle 4 iLdRspVld data=0xAAAA with iAluVld dst=3 data=0x55 -> cycle 5 writes r7=0xAAAA, cycle 6 writes r3=0x55; oPend[7] 1 from cycle 2 until cleared at cycle 5.
REQ-039 Three consecutive ALU results during three load responses -> oAluStall=1 after two enqueued; third dropped, oErr=1.
REQ-040 iLdRspVld with no outstanding load -> no write, oErr=1; iAluVld dst=0 -> no write, oErr stays as before.
REQ-041 Two loads outstanding, resetn pulsed low -> oPend=0, oLdStall=0, subsequent iLdRspVld causes no write and sets oErr.
REQ-042 WB_FWD_EN: iFwdReg=5 while oRegWr writes r5=0x99 -> oFwdHit=1, oFwdData=0x99; iFwdReg=0 -> oFwdHit=0.

Source files
------------

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates load responses and ALU results onto one register-file write port.
// Optional macro WB_FWD_EN adds a combinational forwarding lookup on the registered write.
module wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  iAluVld,
  input  logic [REG_W-1:0]      iAluDst,
  input  logic [DATA_W-1:0]     iAluData,
  input  logic                  iLdIssue,
  input  logic [REG_W-1:0]      iLdDst,
  input  logic                  iLdRspVld,
  input  logic [DATA_W-1:0]     iLdRspData,
  output logic                  oRegWr,
  output logic [REG_W-1:0]      oWrReg3,
  output logic [DATA_W-1:0]     oWrData,
  output logic                  oAluStall,
  output logic                  oLdStall,
  output logic [2**REG_W-1:0]   oPend,
  output logic                  oErr,
  input  logic [REG_W-1:0]      iFwdReg,
  output logic                  oFwdHit,
  output logic [DATA_W-1:0]     oFwdData
);
  localparam int NREG = 2**REG_W;

  logic [REG_W-1:0]  aluDstQ [2];
  logic [DATA_W-1:0] aluDatQ [2];
  logic [1:0]        aluCnt;
  logic [REG_W-1:0]  ldQ [2];
  logic [1:0]        ldCnt;

  logic aluIn, aluPop, aluPush, aluBypass, aluErr;
  logic ldPop, ldPush, ldErr;
  logic [1:0] aluMid, ldMid;
  logic              wrEn;
  logic [REG_W-1:0]  wrReg;
  logic [DATA_W-1:0] wrData;
  logic [NREG-1:0]   pendNxt;

  // Any load response, even an erroneous one, owns the write port for the cycle.
  always_comb begin
    aluIn     = iAluVld && (iAluDst != '0);
    ldPop     = iLdRspVld && (ldCnt != 2'd0);
    ldMid     = ldCnt - {1'b0, ldPop};
    ldPush    = iLdIssue && (ldMid != 2'd2);
    ldErr     = (iLdRspVld && (ldCnt == 2'd0)) || (iLdIssue && !ldPush);
    aluPop    = !iLdRspVld && (aluCnt != 2'd0);
    aluBypass = !iLdRspVld && (aluCnt == 2'd0) && aluIn;
    aluMid    = aluCnt - {1'b0, aluPop};
    aluPush   = aluIn && !aluBypass && (aluMid != 2'd2);
    aluErr    = aluIn && !aluBypass && !aluPush;

    wrEn   = 1'b0;
    wrReg  = iAluDst;
    wrData = iAluData;
    if (ldPop) begin
      wrEn   = (ldQ[0] != '0);
      wrReg  = ldQ[0];
      wrData = iLdRspData;
    end else if (aluPop) begin
      wrEn   = 1'b1;
      wrReg  = aluDstQ[0];
      wrData = aluDatQ[0];
    end else if (aluBypass) begin
      wrEn   = 1'b1;
    end

    // Clear before set so an issue to the same register on the retiring edge wins.
    pendNxt = oPend;
    if (ldPop) pendNxt[ldQ[0]] = 1'b0;
    if (ldPush) pendNxt[iLdDst] = 1'b1;
    pendNxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aluCnt  <= 2'd0;
      ldCnt   <= 2'd0;
      aluDstQ <= '{default: '0};
      aluDatQ <= '{default: '0};
      ldQ     <= '{default: '0};
      oRegWr  <= 1'b0;
      oWrReg3 <= '0;
      oWrData <= '0;
      oPend   <= '0;
      oErr    <= 1'b0;
    end else begin
      if (aluPop) begin
        aluDstQ[0] <= aluDstQ[1];
        aluDatQ[0] <= aluDatQ[1];
      end
      if (aluPush) begin
        aluDstQ[aluMid[0]] <= iAluDst;
        aluDatQ[aluMid[0]] <= iAluData;
      end
      aluCnt <= aluMid + {1'b0, aluPush};
      if (ldPop) ldQ[0] <= ldQ[1];
      if (ldPush) ldQ[ldMid[0]] <= iLdDst;
      ldCnt <= ldMid + {1'b0, ldPush};
      oRegWr <= wrEn;
      if (wrEn) begin
        oWrReg3 <= wrReg;
        oWrData <= wrData;
      end
      oPend <= pendNxt;
      oErr  <= oErr | aluErr | ldErr;
    end
  end

  assign oAluStall = (aluCnt == 2'd2);
  assign oLdStall  = (ldCnt == 2'd2);

`ifdef WB_FWD_EN
  assign oFwdHit  = oRegWr && (oWrReg3 == iFwdReg) && (iFwdReg != '0);
  assign oFwdData = oWrData;
`else
  logic unusedFwd;
  assign unusedFwd = ^iFwdReg;
  assign oFwdHit   = 1'b0;
  assign oFwdData  = '0;
`endif
endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iAluVld = 1'b0;
  logic [4:0]  iAluDst = '0;
  logic [31:0] iAluData = '0;
  logic        iLdIssue = 1'b0;
  logic [4:0]  iLdDst = '0;
  logic        iLdRspVld = 1'b0;
  logic [31:0] iLdRspData = '0;
  logic [4:0]  iFwdReg = '0;
  logic        oRegWr, oAluStall, oLdStall, oErr, oFwdHit;
  logic [4:0]  oWrReg3;
  logic [31:0] oWrData, oPend, oFwdData;

  wb_ctrl dut (
    .clk(clk), .resetn(resetn),
    .iAluVld(iAluVld), .iAluDst(iAluDst), .iAluData(iAluData),
    .iLdIssue(iLdIssue), .iLdDst(iLdDst),
    .iLdRspVld(iLdRspVld), .iLdRspData(iLdRspData),
    .oRegWr(oRegWr), .oWrReg3(oWrReg3), .oWrData(oWrData),
    .oAluStall(oAluStall), .oLdStall(oLdStall), .oPend(oPend), .oErr(oErr),
    .iFwdReg(iFwdReg), .oFwdHit(oFwdHit), .oFwdData(oFwdData)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Reference state: pending ALU results and outstanding load tags in arrival order.
  logic [4:0]  mAluDst[$];
  logic [31:0] mAluData[$];
  logic [4:0]  mLd[$];
  logic        expWr;
  logic [4:0]  expReg;
  logic [31:0] expData, expPend;
  logic        expErr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear();
    mAluDst.delete(); mAluData.delete(); mLd.delete();
    expWr = 0; expReg = 0; expData = 0; expPend = 0; expErr = 0;
  endtask

  task automatic checkOutputs();
    check("oRegWr", 64'(oRegWr), 64'(expWr));
    check("oWrReg3", 64'(oWrReg3), 64'(expReg));
    check("oWrData", 64'(oWrData), 64'(expData));
    check("oAluStall", 64'(oAluStall), 64'(mAluDst.size() == 2));
    check("oLdStall", 64'(oLdStall), 64'(mLd.size() == 2));
    check("oPend", 64'(oPend), 64'(expPend));
    check("oErr", 64'(oErr), 64'(expErr));
  endtask

  task automatic checkFwd();
    logic        hit;
    logic [31:0] dat;
`ifdef WB_FWD_EN
    hit = expWr && (expReg == iFwdReg) && (iFwdReg != 0);
    dat = expData;
`else
    hit = 1'b0;
    dat = 32'h0;
`endif
    check("oFwdHit", 64'(oFwdHit), 64'(hit));
    check("oFwdData", 64'(oFwdData), 64'(dat));
  endtask

  // One cycle of spec-level behaviour: pick the writer, then queue arrivals.
  task automatic modelStep();
    logic       bypassed;
    logic [4:0] t;
    bypassed = 0;
    expWr = 0;
    if (iLdRspVld) begin
      if (mLd.size() == 0) expErr = 1;
      else begin
        t = mLd.pop_front();
        expPend[t] = 1'b0;
        if (t != 0) begin expWr = 1; expReg = t; expData = iLdRspData; end
      end
    end else if (mAluDst.size() > 0) begin
      expWr = 1; expReg = mAluDst.pop_front(); expData = mAluData.pop_front();
    end else if (iAluVld && iAluDst != 0) begin
      expWr = 1; expReg = iAluDst; expData = iAluData; bypassed = 1;
    end
    if (iAluVld && iAluDst != 0 && !bypassed) begin
      if (mAluDst.size() < 2) begin mAluDst.push_back(iAluDst); mAluData.push_back(iAluData); end
      else expErr = 1;
    end
    if (iLdIssue) begin
      if (mLd.size() < 2) begin
        mLd.push_back(iLdDst);
        if (iLdDst != 0) expPend[iLdDst] = 1'b1;
      end else expErr = 1;
    end
    expPend[0] = 1'b0;
  endtask

  task automatic cyc(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                     input logic li, input logic [4:0] ld,
                     input logic rv, input logic [31:0] rd, input logic [4:0] fr);
    iAluVld = av; iAluDst = ad; iAluData = adat;
    iLdIssue = li; iLdDst = ld; iLdRspVld = rv; iLdRspData = rd; iFwdReg = fr;
    #1 checkFwd();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    iAluVld = 0; iLdIssue = 0; iLdRspVld = 0;
    resetn = 0;
    modelClear();
    #1 checkOutputs();
    @(negedge clk);
    resetn = 1;
    checkOutputs();
  endtask

  initial begin
    modelClear();
    doReset();

    // Bypass latency, then deassert.
    cyc(1, 5, 32'h1234, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 5);
    idle(1);

    // Load has priority; pending bit tracks the outstanding load.
    cyc(0, 0, 0, 1, 7, 0, 0, 0);
    idle(2);
    cyc(1, 3, 32'h55, 0, 0, 1, 32'hAAAA, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 3);
    idle(1);

    // Three ALU results under three load responses: third is dropped.
    cyc(0, 0, 0, 1, 9, 0, 0, 0);
    cyc(0, 0, 0, 1, 10, 0, 0, 0);
    cyc(1, 11, 32'h1, 1, 12, 1, 32'hB0, 0);
    cyc(1, 13, 32'h2, 0, 0, 1, 32'hB1, 0);
    cyc(1, 14, 32'h3, 0, 0, 1, 32'hB2, 0);
    idle(4);

    // Spurious response and dst-0 ALU result.
    doReset();
    cyc(0, 0, 0, 0, 0, 1, 32'hDEAD, 0);
    cyc(1, 0, 32'h77, 0, 0, 0, 0, 0);
    idle(1);

    // Load to r0 retires without a write.
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hC0DE, 0);
    idle(1);

    // Reset with two loads outstanding.
    doReset();
    cyc(0, 0, 0, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 1, 6, 0, 0, 0);
    doReset();
    cyc(0, 0, 0, 0, 0, 1, 32'hF00D, 0);
    idle(1);

    // Random traffic, mostly honouring the stalls.
    doReset();
    for (int n = 0; n < 800; n++) begin
      logic av, li, rv;
      av = ($urandom_range(0, 1) == 1);
      if (mAluDst.size() == 2 && $urandom_range(0, 7) != 0) av = 0;
      li = ($urandom_range(0, 2) == 0);
      if (mLd.size() == 2 && $urandom_range(0, 7) != 0) li = 0;
      rv = (mLd.size() > 0) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 15) == 0);
      if (n % 200 == 199) doReset();
      cyc(av, 5'($urandom_range(0, 7)), $urandom, li, 5'($urandom_range(0, 7)),
          rv, $urandom, 5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
